// File: rtl/sramc_port_arbiter_pkg.sv
// Shared types and constants for the SRAM C port arbiter (core vs. DMA).
package sramc_port_arbiter_pkg;

  localparam int SRAMC_W      = 256;
  localparam int ADRC_W       = 12;
  localparam int ARB_STARVE_W = 8;

  typedef enum logic {
    ARB_CORE = 1'b0,
    ARB_DMA  = 1'b1
  } arb_id_e;

  typedef struct packed {
    logic                   wren;
    logic [ADRC_W-1:0]      addr;
    logic [SRAMC_W-1:0]     wdata;
    logic [SRAMC_W/8-1:0]   wmask;
  } sramc_req_t;

endpackage

// File: rtl/sramc_rsp_tracker.sv
// Read-response tracker: a {valid, id} shift register aligned to the SRAM read
// latency that steers returning read data to the requester that issued it.
module sramc_rsp_tracker
  import sramc_port_arbiter_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int DATA_W = SRAMC_W
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_push_vld,
  input  arb_id_e           i_push_id,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  output logic              o_dma_rvalid,
  output logic [DATA_W-1:0] o_dma_rdata
);

  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  id_q, id_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              core_hit, dma_hit;

  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = i_push_vld;
    id_d[0]  = i_push_vld & (i_push_id == ARB_DMA);
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
    core_hit = vld_q[DEPTH-1] & (arb_id_e'(id_q[DEPTH-1]) == ARB_CORE);
    dma_hit  = vld_q[DEPTH-1] & (arb_id_e'(id_q[DEPTH-1]) == ARB_DMA);
    // Data passes straight through on the hit cycle and is held afterwards.
    core_rdata_d = core_hit ? i_sram_rdata : core_rdata_q;
    dma_rdata_d  = dma_hit  ? i_sram_rdata : dma_rdata_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q        <= '0;
      id_q         <= '0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      vld_q        <= vld_d;
      id_q         <= id_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign o_core_rvalid = core_hit;
  assign o_core_rdata  = core_rdata_d;
  assign o_dma_rvalid  = dma_hit;
  assign o_dma_rdata   = dma_rdata_d;

endmodule

// File: rtl/sramc_port_arbiter.sv
// Core/DMA arbiter for the single-port SRAM C: core priority, DMA anti-starvation.
// Define SRAMC_ARB_OUTREG_EN to register the SRAM command outputs (+1 cycle latency).
module sramc_port_arbiter
  import sramc_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = SRAMC_W,
  parameter int ADDR_W     = ADRC_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_core_req,
  input  logic                i_core_wren,
  input  logic [ADDR_W-1:0]   i_core_addr,
  input  logic [DATA_W-1:0]   i_core_wdata,
  input  logic [DATA_W/8-1:0] i_core_wmask,
  input  logic                i_core_lock,
  output logic                o_core_gnt,
  output logic                o_core_rvalid,
  output logic [DATA_W-1:0]   o_core_rdata,
  input  logic                i_dma_req,
  input  logic                i_dma_wren,
  input  logic [ADDR_W-1:0]   i_dma_addr,
  input  logic [DATA_W-1:0]   i_dma_wdata,
  input  logic [DATA_W/8-1:0] i_dma_wmask,
  output logic                o_dma_gnt,
  output logic                o_dma_rvalid,
  output logic [DATA_W-1:0]   o_dma_rdata,
  output logic                o_sram_cen,
  output logic                o_sram_wen,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [DATA_W-1:0]   o_sram_wdata,
  output logic [DATA_W/8-1:0] o_sram_wmask,
  input  logic [DATA_W-1:0]   i_sram_rdata,
  output logic [7:0]          o_starve_cnt
);

  localparam logic [ARB_STARVE_W-1:0] STARVE_TH = ARB_STARVE_W'(STARVE_MAX);

  logic [ARB_STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                    force_dma, core_gnt, dma_gnt, cen_d, rd_push;
  arb_id_e                 push_id;
  sramc_req_t              core_cmd, dma_cmd, cmd_d;

  always_comb begin
    core_cmd = '{wren: i_core_wren, addr: i_core_addr, wdata: i_core_wdata, wmask: i_core_wmask};
    dma_cmd  = '{wren: i_dma_wren,  addr: i_dma_addr,  wdata: i_dma_wdata,  wmask: i_dma_wmask};

    // The lock only blocks the forced grant; an idle core still lets the DMA in.
    force_dma = i_dma_req & (starve_cnt_q >= STARVE_TH) & ~i_core_lock;
    dma_gnt   = force_dma | (i_dma_req & ~i_core_req);
    core_gnt  = i_core_req & ~dma_gnt;
    cen_d     = core_gnt | dma_gnt;

    cmd_d = '0;
    if (dma_gnt) begin
      cmd_d = dma_cmd;
    end else if (core_gnt) begin
      cmd_d = core_cmd;
    end
    rd_push = cen_d & ~cmd_d.wren;
    push_id = dma_gnt ? ARB_DMA : ARB_CORE;

    starve_cnt_d = starve_cnt_q;
    if (!i_dma_req || dma_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != '1) begin
      starve_cnt_d = starve_cnt_q + ARB_STARVE_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

`ifdef SRAMC_ARB_OUTREG_EN
  localparam int TRK_DEPTH = RD_LAT + 1;

  logic       cen_q;
  sramc_req_t cmd_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cen_q <= 1'b0;
      cmd_q <= '0;
    end else begin
      cen_q <= cen_d;
      cmd_q <= cmd_d;
    end
  end

  assign o_sram_cen   = cen_q;
  assign o_sram_wen   = cmd_q.wren;
  assign o_sram_addr  = cmd_q.addr;
  assign o_sram_wdata = cmd_q.wdata;
  assign o_sram_wmask = cmd_q.wmask;
`else
  localparam int TRK_DEPTH = RD_LAT;

  assign o_sram_cen   = cen_d;
  assign o_sram_wen   = cmd_d.wren;
  assign o_sram_addr  = cmd_d.addr;
  assign o_sram_wdata = cmd_d.wdata;
  assign o_sram_wmask = cmd_d.wmask;
`endif

  sramc_rsp_tracker #(
    .DEPTH  (TRK_DEPTH),
    .DATA_W (DATA_W)
  ) u_rsp_tracker (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_push_vld    (rd_push),
    .i_push_id     (push_id),
    .i_sram_rdata  (i_sram_rdata),
    .o_core_rvalid (o_core_rvalid),
    .o_core_rdata  (o_core_rdata),
    .o_dma_rvalid  (o_dma_rvalid),
    .o_dma_rdata   (o_dma_rdata)
  );

  assign o_core_gnt   = core_gnt;
  assign o_dma_gnt    = dma_gnt;
  assign o_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_sramc_port_arbiter.sv
// Bench for sramc_port_arbiter: vector table, directed corner sequences and a
// randomized run, all checked against a cycle-level reference model.
module tb_sramc_port_arbiter;

  localparam int DATA_W     = 256;
  localparam int ADDR_W     = 12;
  localparam int MW         = DATA_W / 8;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;
`ifdef SRAMC_ARB_OUTREG_EN
  localparam int CMD_DLY = 1;
`else
  localparam int CMD_DLY = 0;
`endif
  localparam int LAT = RD_LAT + CMD_DLY;

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              rstn;
  logic              core_req, core_wren, core_lock, dma_req, dma_wren;
  logic [ADDR_W-1:0] core_addr, dma_addr;
  logic [DATA_W-1:0] core_wdata, dma_wdata;
  logic [MW-1:0]     core_wmask, dma_wmask;
  logic              core_gnt, core_rvalid, dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] core_rdata, dma_rdata;
  logic              sram_cen, sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic [MW-1:0]     sram_wmask;
  logic [7:0]        starve_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sramc_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_core_req(core_req), .i_core_wren(core_wren), .i_core_addr(core_addr),
    .i_core_wdata(core_wdata), .i_core_wmask(core_wmask), .i_core_lock(core_lock),
    .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid), .o_core_rdata(core_rdata),
    .i_dma_req(dma_req), .i_dma_wren(dma_wren), .i_dma_addr(dma_addr),
    .i_dma_wdata(dma_wdata), .i_dma_wmask(dma_wmask),
    .o_dma_gnt(dma_gnt), .o_dma_rvalid(dma_rvalid), .o_dma_rdata(dma_rdata),
    .o_sram_cen(sram_cen), .o_sram_wen(sram_wen), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .o_sram_wmask(sram_wmask),
    .i_sram_rdata(sram_rdata), .o_starve_cnt(starve_cnt)
  );

  // SRAM stand-in: read data is a fixed function of the address, RD_LAT cycles later.
  function automatic logic [DATA_W-1:0] rd_pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = {20'b0, a} + 32'h0000_0A00;
    return {w ^ 32'h7000_0000, w ^ 32'h0600_0000, w ^ 32'h0050_0000, w ^ 32'h0004_0000,
            w ^ 32'h3000_0000, w ^ 32'h0200_0000, w ^ 32'h0010_0000, w};
  endfunction

  logic [DATA_W-1:0] sram_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) sram_pipe[i] <= sram_pipe[i-1];
    sram_pipe[0] <= (sram_cen && !sram_wen) ? rd_pattern(sram_addr) : '0;
  end
  assign sram_rdata = sram_pipe[RD_LAT-1];

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int                due;
    logic              id;   // 1 = DMA
    logic [DATA_W-1:0] data;
  } rsp_t;
  rsp_t exp_q[$];

  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  int                starve_m;
  logic              m_core_gnt, m_dma_gnt;
  logic [DATA_W-1:0] held_core, held_dma;
  logic              prev_cen, prev_wen;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_wdata;
  logic [MW-1:0]     prev_wmask;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    starve_m   = 0;
    held_core  = '0;
    held_dma   = '0;
    prev_cen   = 1'b0;
    prev_wen   = 1'b0;
    prev_addr  = '0;
    prev_wdata = '0;
    prev_wmask = '0;
    m_core_gnt = 1'b0;
    m_dma_gnt  = 1'b0;
  endtask

  // Called mid-cycle: compares every output, then advances the model one clock.
  task automatic model_cycle();
    logic              e_cen, e_wen, e_crv, e_drv;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [MW-1:0]     e_wmask;
    rsp_t              r;
    m_dma_gnt  = dma_req && (starve_m >= STARVE_MAX) && !core_lock;
    m_dma_gnt  = m_dma_gnt || (dma_req && !core_req);
    m_core_gnt = core_req && !m_dma_gnt;
    check("core_gnt", core_gnt, m_core_gnt);
    check("dma_gnt", dma_gnt, m_dma_gnt);
    check("starve_cnt", starve_cnt, starve_m);

    e_cen = m_core_gnt || m_dma_gnt;
    e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_wmask = '0;
    if (m_dma_gnt) begin
      e_wen = dma_wren; e_addr = dma_addr; e_wdata = dma_wdata; e_wmask = dma_wmask;
    end else if (m_core_gnt) begin
      e_wen = core_wren; e_addr = core_addr; e_wdata = core_wdata; e_wmask = core_wmask;
    end
    if (e_cen && !e_wen) exp_q.push_back('{cyc + LAT, m_dma_gnt, rd_pattern(e_addr)});
    if (CMD_DLY == 1) begin
      check("sram_cen", sram_cen, prev_cen);
      check("sram_wen", sram_wen, prev_wen);
      check("sram_addr", sram_addr, prev_addr);
      check("sram_wdata", sram_wdata, prev_wdata);
      check("sram_wmask", sram_wmask, prev_wmask);
    end else begin
      check("sram_cen", sram_cen, e_cen);
      check("sram_wen", sram_wen, e_wen);
      check("sram_addr", sram_addr, e_addr);
      check("sram_wdata", sram_wdata, e_wdata);
      check("sram_wmask", sram_wmask, e_wmask);
    end
    prev_cen = e_cen; prev_wen = e_wen; prev_addr = e_addr; prev_wdata = e_wdata; prev_wmask = e_wmask;

    e_crv = 1'b0; e_drv = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      if (r.id) begin e_drv = 1'b1; held_dma = r.data; end
      else      begin e_crv = 1'b1; held_core = r.data; end
    end
    check("core_rvalid", core_rvalid, e_crv);
    check("dma_rvalid", dma_rvalid, e_drv);
    check("core_rdata", core_rdata, held_core);
    check("dma_rdata", dma_rdata, held_dma);

    if (!dma_req || m_dma_gnt) starve_m = 0;
    else if (starve_m < 255)   starve_m = starve_m + 1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic wr, input logic [ADDR_W-1:0] a, input logic lk);
    core_req = req; core_wren = wr; core_addr = a; core_lock = lk;
    core_wdata = {8{$urandom}}; core_wmask = $urandom;
  endtask

  task automatic drive_dma(input logic req, input logic wr, input logic [ADDR_W-1:0] a, input logic [MW-1:0] m);
    dma_req = req; dma_wren = wr; dma_addr = a; dma_wmask = m;
    dma_wdata = {8{$urandom}};
  endtask

  task automatic idle(input int n);
    drive_core(1'b0, 1'b0, '0, 1'b0);
    drive_dma(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts reset asynchronously, checks all outputs are zero while held.
  task automatic do_reset(input int n);
    drive_core(1'b0, 1'b0, '0, 1'b0);
    drive_dma(1'b0, 1'b0, '0, '0);
    rstn = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_core_gnt", core_gnt, 1'b0);
      check("rst_dma_gnt", dma_gnt, 1'b0);
      check("rst_core_rvalid", core_rvalid, 1'b0);
      check("rst_dma_rvalid", dma_rvalid, 1'b0);
      check("rst_core_rdata", core_rdata, '0);
      check("rst_dma_rdata", dma_rdata, '0);
      check("rst_sram_cen", sram_cen, 1'b0);
      check("rst_sram_wen", sram_wen, 1'b0);
      check("rst_sram_addr", sram_addr, '0);
      check("rst_sram_wdata", sram_wdata, '0);
      check("rst_sram_wmask", sram_wmask, '0);
      check("rst_starve_cnt", starve_cnt, '0);
      @(posedge clk);
      #1;
      cyc++;
    end
    model_reset();
    rstn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              cr, cw;
    logic [ADDR_W-1:0] ca;
    logic              lk, dr, dw;
    logic [ADDR_W-1:0] da;
    logic [MW-1:0]     dm;
    logic              ecg, edg;
  } vec_t;
  vec_t vt[15];

  int dma_wins;

  initial begin
    rstn = 1'b0;
    model_reset();
    vt[0]  = '{1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 12'h011, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 12'h012, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 12'h013, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 12'h005, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h105, 32'h0, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h0FF, 32'h0000_000F, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 12'h020, 1'b0, 1'b1, 1'b0, 12'h120, 32'h0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h120, 32'h0, 1'b0, 1'b1};
    vt[13] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h121, 32'h0, 1'b0, 1'b1};
    vt[14] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0};

    #1;
    do_reset(3);

    for (int i = 0; i < 15; i++) begin
      drive_core(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].lk);
      drive_dma(vt[i].dr, vt[i].dw, vt[i].da, vt[i].dm);
      @(negedge clk);
      check($sformatf("vec%0d_core_gnt", i), core_gnt, vt[i].ecg);
      check($sformatf("vec%0d_dma_gnt", i), dma_gnt, vt[i].edg);
      model_cycle();
      @(posedge clk);
      #1;
    end
    idle(LAT + 1);

    // Starvation force: DMA must win the 9th and 18th cycle of continuous contention.
    for (int i = 0; i < 18; i++) begin
      drive_core(1'b1, 1'b0, 12'h030 + ADDR_W'(i), 1'b0);
      drive_dma(1'b1, 1'b0, 12'h130 + ADDR_W'(i), '0);
      @(negedge clk);
      check($sformatf("starve_seq%0d_dma_gnt", i), dma_gnt, (i == 8 || i == 17));
      model_cycle();
      @(posedge clk);
      #1;
    end
    idle(LAT + 1);

    // Core lock holds off the DMA indefinitely; release grants the DMA at once.
    dma_wins = 0;
    for (int i = 0; i < 300; i++) begin
      drive_core(1'b1, 1'b0, ADDR_W'(i), 1'b1);
      drive_dma(1'b1, 1'b0, 12'h200, '0);
      @(negedge clk);
      if (dma_gnt) dma_wins++;
      model_cycle();
      @(posedge clk);
      #1;
    end
    check("lock_dma_wins", dma_wins, 0);
    check("lock_starve_sat", starve_cnt, 8'd255);
    drive_core(1'b1, 1'b0, 12'h300, 1'b0);
    @(negedge clk);
    check("unlock_dma_gnt", dma_gnt, 1'b1);
    check("unlock_core_gnt", core_gnt, 1'b0);
    model_cycle();
    @(posedge clk);
    #1;
    idle(LAT + 1);

    // Reset one cycle after a granted read: that read must never return.
    drive_core(1'b1, 1'b0, 12'h055, 1'b0);
    step();
    do_reset(3);
    idle(LAT + 3);

    // Randomized traffic; payload is held until the model says it was accepted.
    drive_core(1'b0, 1'b0, '0, 1'b0);
    drive_dma(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 2000; i++) begin
      if (!core_req || m_core_gnt)
        drive_core($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                   ADDR_W'($urandom), core_lock);
      if (!dma_req || m_dma_gnt)
        drive_dma($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                  ADDR_W'($urandom), MW'($urandom));
      if ($urandom_range(0, 63) == 0) core_lock = ~core_lock;
      step();
    end
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
